register_bank: RTL and testbench

- Parametrised bank of NUM_REGS registers of WIDTH bits, sharing one data bus.
- Successor to the single latch/enable bus register.
- Per-cycle operations on an addressed register: load from bus, drive to bus, increment, decrement.
- Adds a 2-cycle register-to-register transfer over the bus, run by a small FSM.
- Sits between the bus driver/tristate logic in the top level and the LED/display logic.

---
 rtl/register_bank_pkg.sv | 28 ++
 rtl/bus_xfer_fsm.sv | 56 +++++
 rtl/register_bank.sv | 111 +++++++++++
 tb/tb_register_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared types and defaults for the register bank and its transfer FSM.
// Also imported by the top level and LED logic for bank geometry.
package register_bank_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOAD
  } xfer_state_e;

  // Highest priority first: xfer > latch > inc > dec
  localparam int PRIO_XFER  = 0;
  localparam int PRIO_LATCH = 1;
  localparam int PRIO_INC   = 2;
  localparam int PRIO_DEC   = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_XFER,
    OP_LATCH,
    OP_INC,
    OP_DEC
  } op_e;

endpackage

// File: rtl/bus_xfer_fsm.sv
// Two-cycle register-to-register transfer sequencer.
// Latches src/dst on start and walks IDLE -> DRIVE -> LOAD -> IDLE.
module bus_xfer_fsm
  import register_bank_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              load_o
);

  xfer_state_e       state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        src_q <= src_i;
        dst_q <= dst_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = DRIVE;
      DRIVE:   state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == LOAD);
    load_o = (state_q == LOAD);
  end

  assign src_o = src_q;
  assign dst_o = dst_q;

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers sharing one bus: load, drive, inc/dec,
// plus a sequenced register-to-register transfer over the bus.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NUM_REGS  = DEF_NUM_REGS,
  parameter int               ADDR_W    = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic              enable,
  input  logic              inc,
  input  logic              dec,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [ADDR_W-1:0] rd_sel,
  input  logic              xfer_start,
  input  logic [WIDTH-1:0]  bus_in,
  output logic [WIDTH-1:0]  bus_out,
  output logic              bus_oe,
  output logic [WIDTH-1:0]  reg_out,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] SEL_LIM = (ADDR_W+1)'(NUM_REGS);

  logic [WIDTH-1:0]  reg_q [NUM_REGS];
  logic [WIDTH-1:0]  rd_val, src_val;
  logic [ADDR_W-1:0] x_src, x_dst;
  logic              rd_ok, wr_ok, start_ok;
  logic              f_busy, f_done, f_load;
  op_e               op;

  assign rd_ok = ({1'b0, rd_sel} < SEL_LIM);
  assign wr_ok = ({1'b0, wr_sel} < SEL_LIM);

  always_comb begin
    op = OP_NONE;
    priority case (1'b1)
      xfer_start: op = OP_XFER;
      latch:      op = OP_LATCH;
      inc:        op = OP_INC;
      dec:        op = OP_DEC;
      default:    op = OP_NONE;
    endcase
  end

  // Out-of-range endpoints make the whole transfer a no-op
  assign start_ok = !f_busy && (op == OP_XFER) && rd_ok && wr_ok;

  bus_xfer_fsm #(
    .ADDR_W(ADDR_W)
  ) u_fsm (
    .clk    (clk),
    .reset  (reset),
    .start_i(start_ok),
    .src_i  (rd_sel),
    .dst_i  (wr_sel),
    .src_o  (x_src),
    .dst_o  (x_dst),
    .busy_o (f_busy),
    .done_o (f_done),
    .load_o (f_load)
  );

  always_comb begin
    rd_val  = '0;
    src_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == ADDR_W'(i)) rd_val = reg_q[i];
      if (x_src == ADDR_W'(i)) src_val = reg_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
    end else if (f_load) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (x_dst == ADDR_W'(i)) reg_q[i] <= src_val;
    end else if (!f_busy && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel == ADDR_W'(i)) begin
          unique case (op)
            OP_LATCH: reg_q[i] <= bus_in;
            OP_INC:   reg_q[i] <= reg_q[i] + WIDTH'(1);
            OP_DEC:   reg_q[i] <= reg_q[i] - WIDTH'(1);
            default:  ;
          endcase
        end
      end
    end
  end

  // Reset forces the bus quiet and hides a transfer being aborted
  always_comb begin
    busy    = f_busy && !reset;
    done    = f_done && !reset;
    reg_out = rd_val;
    bus_oe  = !reset && (f_busy || enable);
    bus_out = '0;
    if (!reset) begin
      if (f_busy)      bus_out = src_val;
      else if (enable) bus_out = rd_val;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: 4-reg and 3-reg instances against a model.
// Directed vectors plus per-cycle comparison of every output.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        reset, latch, enable, inc, dec, xfer_start;
  logic [1:0]  wr_sel, rd_sel;
  logic [15:0] bus_in;

  logic [15:0] bo4, ro4, bo3, ro3;
  logic        oe4, by4, dn4, oe3, by3, dn3;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  register_bank u4 (
    .clk(clk), .reset(reset), .latch(latch), .enable(enable),
    .inc(inc), .dec(dec), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .xfer_start(xfer_start), .bus_in(bus_in), .bus_out(bo4),
    .bus_oe(oe4), .reg_out(ro4), .busy(by4), .done(dn4)
  );

  register_bank #(.NUM_REGS(3)) u3 (
    .clk(clk), .reset(reset), .latch(latch), .enable(enable),
    .inc(inc), .dec(dec), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .xfer_start(xfer_start), .bus_in(bus_in), .bus_out(bo3),
    .bus_oe(oe3), .reg_out(ro3), .busy(by3), .done(dn3)
  );

  // Model: k=0 is the 4-reg bank, k=1 the 3-reg bank
  int          nregs [2] = '{4, 3};
  logic [15:0] m     [2][4];
  int          phase [2];
  int          msrc  [2];
  int          mdst  [2];

  function automatic logic [15:0] mread(int k, int sel);
    return (sel < nregs[k]) ? m[k][sel] : 16'h0000;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int r = 0; r < 4; r++) m[k][r] = 16'h0000;
        phase[k] = 0;
      end else if (phase[k] == 1) begin
        phase[k] = 2;
      end else if (phase[k] == 2) begin
        m[k][mdst[k]] = m[k][msrc[k]];
        phase[k] = 0;
      end else if (xfer_start) begin
        if (int'(rd_sel) < nregs[k] && int'(wr_sel) < nregs[k]) begin
          msrc[k]  = int'(rd_sel);
          mdst[k]  = int'(wr_sel);
          phase[k] = 1;
        end
      end else if (int'(wr_sel) < nregs[k]) begin
        if (latch)    m[k][wr_sel] = bus_in;
        else if (inc) m[k][wr_sel] = m[k][wr_sel] + 16'd1;
        else if (dec) m[k][wr_sel] = m[k][wr_sel] - 16'd1;
      end
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic [15:0] bo, logic oe, logic [15:0] ro,
                     logic by, logic dn);
    logic [15:0] e_bo;
    logic        e_oe, e_by, e_dn;
    e_by = !reset && phase[k] != 0;
    e_dn = !reset && phase[k] == 2;
    e_oe = !reset && (phase[k] != 0 || enable);
    e_bo = 16'h0000;
    if (!reset && phase[k] != 0) e_bo = m[k][msrc[k]];
    else if (!reset && enable)   e_bo = mread(k, int'(rd_sel));
    check($sformatf("m%0d.reg_out", k), ro, mread(k, int'(rd_sel)));
    check($sformatf("m%0d.bus_out", k), bo, e_bo);
    check($sformatf("m%0d.bus_oe", k), {15'd0, oe}, {15'd0, e_oe});
    check($sformatf("m%0d.busy", k), {15'd0, by}, {15'd0, e_by});
    check($sformatf("m%0d.done", k), {15'd0, dn}, {15'd0, e_dn});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, bo4, oe4, ro4, by4, dn4);
      cmp(1, bo3, oe3, ro3, by3, dn3);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    latch = 0; enable = 0; inc = 0; dec = 0; xfer_start = 0;
  endtask

  initial begin
    idle_in();
    reset = 1; wr_sel = 0; rd_sel = 0; bus_in = 16'h0000;
    cyc(); cyc();
    reset = 0;
    chk_en = 1'b1;

    // Reset state on every select
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      @(negedge clk);
      check("rst reg_out", ro4, 16'h0000);
      check("rst bus_oe", {15'd0, oe4}, 16'h0000);
      check("rst busy", {15'd0, by4}, 16'h0000);
      cyc();
    end

    // Latch then drive
    wr_sel = 2; bus_in = 16'h5500; latch = 1;
    cyc(); idle_in();
    rd_sel = 2; enable = 1;
    @(negedge clk);
    check("latch reg_out", ro4, 16'h5500);
    check("latch bus_out", bo4, 16'h5500);
    check("latch bus_oe", {15'd0, oe4}, 16'h0001);
    cyc(); idle_in();

    // Latch + enable same reg: bus shows old, reg takes new
    latch = 1; enable = 1; bus_in = 16'h0F0F;
    @(negedge clk);
    check("rw bus_out old", bo4, 16'h5500);
    cyc(); idle_in();
    check("rw reg new", ro4, 16'h0F0F);

    // Wrap on inc/dec, latch beats inc
    wr_sel = 1; rd_sel = 1; bus_in = 16'hFFFF; latch = 1;
    cyc(); idle_in(); inc = 1;
    cyc(); idle_in();
    check("inc wrap", ro4, 16'h0000);
    dec = 1;
    cyc(); idle_in();
    check("dec wrap", ro4, 16'hFFFF);
    latch = 1; inc = 1; bus_in = 16'h1234;
    cyc(); idle_in();
    check("latch>inc", ro4, 16'h1234);

    // Transfer reg0 -> reg3, with latch/inc during busy
    wr_sel = 0; bus_in = 16'hA5A5; latch = 1;
    cyc(); idle_in();
    rd_sel = 0; wr_sel = 3; xfer_start = 1;
    cyc(); idle_in();
    latch = 1; inc = 1; bus_in = 16'h1111; rd_sel = 1;
    @(negedge clk);
    check("x1 busy", {15'd0, by4}, 16'h0001);
    check("x1 oe", {15'd0, oe4}, 16'h0001);
    check("x1 bus", bo4, 16'hA5A5);
    check("x1 done", {15'd0, dn4}, 16'h0000);
    cyc();
    @(negedge clk);
    check("x2 busy", {15'd0, by4}, 16'h0001);
    check("x2 bus", bo4, 16'hA5A5);
    check("x2 done", {15'd0, dn4}, 16'h0001);
    cyc(); idle_in();
    rd_sel = 3;
    @(negedge clk);
    check("x busy off", {15'd0, by4}, 16'h0000);
    check("x dst", ro4, 16'hA5A5);
    cyc();
    rd_sel = 0;
    @(negedge clk);
    check("x src kept", ro4, 16'hA5A5);
    cyc();

    // src == dst
    rd_sel = 2; wr_sel = 2; xfer_start = 1;
    cyc(); idle_in(); cyc();
    @(negedge clk);
    check("self done", {15'd0, dn4}, 16'h0001);
    cyc();
    check("self value", ro4, 16'h0F0F);

    // Reset during DRIVE
    rd_sel = 0; wr_sel = 1; xfer_start = 1;
    cyc(); idle_in();
    reset = 1;
    @(negedge clk);
    check("rx done", {15'd0, dn4}, 16'h0000);
    cyc(); reset = 0;
    @(negedge clk);
    check("rx busy", {15'd0, by4}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      @(negedge clk);
      check("rx regs", ro4, 16'h0000);
      cyc();
    end

    // 3-register bank: out-of-range select
    wr_sel = 3; bus_in = 16'h00FF; latch = 1;
    cyc(); idle_in();
    rd_sel = 3; enable = 1;
    @(negedge clk);
    check("oor reg_out", ro3, 16'h0000);
    check("oor bus_out", bo3, 16'h0000);
    check("oor bus_oe", {15'd0, oe3}, 16'h0001);
    cyc(); idle_in();
    for (int i = 0; i < 3; i++) begin
      rd_sel = 2'(i);
      @(negedge clk);
      check("oor untouched", ro3, 16'h0000);
      cyc();
    end
    rd_sel = 0; wr_sel = 3; xfer_start = 1;
    cyc(); idle_in();
    @(negedge clk);
    check("oor x busy", {15'd0, by3}, 16'h0000);
    check("oor x 4reg busy", {15'd0, by4}, 16'h0001);
    cyc();
    @(negedge clk);
    check("oor x done", {15'd0, dn3}, 16'h0000);
    cyc(); cyc();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
